multicycle_control_unit: RTL and testbench

- Multicycle FSM controller that drives the processor datapath's control inputs.
- Consumes the 16-bit instruction register value and the ALU overflow flag; emits every datapath control strobe and mux select.
- Together with the datapath it forms the full processor: datapath → controller (instruction, overflow), controller → datapath (all control lines).
- One instruction executes in 3–5 cycles.

---
 rtl/control_pkg.sv | 78 +++++++
 rtl/control_decode.sv | 33 +++
 rtl/multicycle_control_unit.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// opcodes, ALU operations, datapath mux codes and the control-word bundle.
package control_pkg;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        CL_ALU, CL_ADDI, CL_LW, CL_SW, CL_BEQ, CL_J, CL_JAL,
        CL_JR, CL_IN, CL_OUT, CL_HALT, CL_ILLEGAL
    } iclass_e;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_AND  = 6'd2;
    localparam logic [5:0] OP_OR   = 6'd3;
    localparam logic [5:0] OP_ADDI = 6'd4;
    localparam logic [5:0] OP_LW   = 6'd5;
    localparam logic [5:0] OP_SW   = 6'd6;
    localparam logic [5:0] OP_BEQ  = 6'd7;
    localparam logic [5:0] OP_J    = 6'd8;
    localparam logic [5:0] OP_JAL  = 6'd9;
    localparam logic [5:0] OP_JR   = 6'd10;
    localparam logic [5:0] OP_IN   = 6'd11;
    localparam logic [5:0] OP_OUT  = 6'd12;
    localparam logic [5:0] OP_HALT = 6'd63;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_PASS_A = 4'd4;

    localparam logic [1:0] MS_PC    = 2'd0;
    localparam logic [1:0] MS_SP    = 2'd1;
    localparam logic [1:0] MS_COMP  = 2'd2;
    localparam logic [2:0] PC_INC   = 3'd0;
    localparam logic [2:0] PC_ZEXT  = 3'd1;
    localparam logic [2:0] PC_RA    = 3'd2;
    localparam logic [2:0] PC_BEQ   = 3'd3;
    localparam logic [1:0] SB_SHELLEY = 2'd0;
    localparam logic [1:0] SB_SEXT    = 2'd1;
    localparam logic [1:0] SB_LS      = 2'd2;
    localparam logic [1:0] MSRC_ALU = 2'd0;
    localparam logic [1:0] MSRC_MEM = 2'd1;
    localparam logic [1:0] MSRC_IO  = 2'd2;
    localparam logic       RA_PC    = 1'b1;
    localparam logic [2:0] MD_IO    = 3'd1;

    typedef struct packed {
        logic       mem_write;
        logic       pc_write;
        logic       sp_write;
        logic       inst_write;
        logic       mary_write;
        logic       shelley_write;
        logic       comp_write;
        logic       ra_write;
        logic [1:0] mem_src;
        logic [2:0] mem_dst;
        logic [2:0] pc_src;
        logic [1:0] sp_src;
        logic [1:0] mary_src;
        logic [1:0] shelley_src;
        logic       ra_src;
        logic       src_a;
        logic [1:0] src_b;
        logic [3:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: maps the 6-bit opcode to an instruction class
// and, for register-register ALU ops, the ALU operation code.
module control_decode
    import control_pkg::*;
(
    input  logic [5:0] opcode_i,
    output iclass_e    iclass_o,
    output logic [3:0] alu_op_o
);

    always_comb begin
        iclass_o = CL_ILLEGAL;
        alu_op_o = ALU_ADD;
        case (opcode_i)
            OP_ADD:  begin iclass_o = CL_ALU; alu_op_o = ALU_ADD; end
            OP_SUB:  begin iclass_o = CL_ALU; alu_op_o = ALU_SUB; end
            OP_AND:  begin iclass_o = CL_ALU; alu_op_o = ALU_AND; end
            OP_OR:   begin iclass_o = CL_ALU; alu_op_o = ALU_OR;  end
            OP_ADDI: iclass_o = CL_ADDI;
            OP_LW:   iclass_o = CL_LW;
            OP_SW:   iclass_o = CL_SW;
            OP_BEQ:  iclass_o = CL_BEQ;
            OP_J:    iclass_o = CL_J;
            OP_JAL:  iclass_o = CL_JAL;
            OP_JR:   iclass_o = CL_JR;
            OP_IN:   iclass_o = CL_IN;
            OP_OUT:  iclass_o = CL_OUT;
            OP_HALT: iclass_o = CL_HALT;
            default: iclass_o = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle FSM controller for the processor datapath; every control line is
// registered and reflects the state currently held in state_dbg.
module multicycle_control_unit
    import control_pkg::*;
#(
    parameter int unsigned RESET_PC_CYCLES = 1,
    parameter logic        HALT_ON_ILLEGAL = 1'b1
)(
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic        overflow,
    output logic        MemWrite,
    output logic        PCWrite,
    output logic        SPWrite,
    output logic        InstWrite,
    output logic        mary_write,
    output logic        shelley_write,
    output logic        comp_write,
    output logic        ra_write,
    output logic [1:0]  MemSrc,
    output logic [2:0]  MemDst,
    output logic [2:0]  PCSrc,
    output logic [1:0]  SPSrc,
    output logic [1:0]  mary_src,
    output logic [1:0]  shelley_src,
    output logic        ra_src,
    output logic        SrcA,
    output logic [1:0]  SrcB,
    output logic [3:0]  AluOp,
    output logic        halted,
    output logic        illegal,
    output logic        overflow_sticky,
    output logic [2:0]  state_dbg
);

    localparam logic [1:0] RST_LAST = 2'(RESET_PC_CYCLES - 1);

    state_e     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic [1:0] rst_cnt_q;
    logic       illegal_q, ovf_q;
    iclass_e    iclass;
    logic [3:0] alu_op;
    logic       alu_class;
    logic       unused_imm;

    control_decode u_decode (
        .opcode_i (instruction[15:10]),
        .iclass_o (iclass),
        .alu_op_o (alu_op)
    );

    assign alu_class  = (iclass == CL_ALU) || (iclass == CL_ADDI);
    assign unused_imm = ^instruction[9:1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  if (rst_cnt_q == RST_LAST) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (iclass)
                    CL_HALT:    state_d = S_HALT;
                    CL_ILLEGAL: state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    default:    state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (iclass)
                    CL_ALU, CL_ADDI: state_d = S_WB;
                    CL_LW, CL_SW:    state_d = S_MEM;
                    default:         state_d = S_FETCH;
                endcase
            end
            S_MEM:   state_d = (iclass == CL_LW) ? S_WB : S_FETCH;
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    // Control word for the state being entered, so it is registered alongside it.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH: begin
                ctrl_d.mem_src    = MS_PC;
                ctrl_d.inst_write = 1'b1;
                ctrl_d.pc_write   = 1'b1;
                ctrl_d.pc_src     = PC_INC;
            end
            S_EXEC: begin
                case (iclass)
                    CL_ALU: begin
                        ctrl_d.src_b  = SB_SHELLEY;
                        ctrl_d.alu_op = alu_op;
                    end
                    CL_ADDI: begin
                        ctrl_d.src_b  = SB_SEXT;
                        ctrl_d.alu_op = ALU_ADD;
                    end
                    CL_LW, CL_SW: begin
                        ctrl_d.src_b      = SB_LS;
                        ctrl_d.alu_op     = ALU_ADD;
                        ctrl_d.comp_write = 1'b1;
                    end
                    CL_BEQ: begin
                        // Datapath qualifies the PC write with ALU zero under PC_BEQ.
                        ctrl_d.alu_op   = ALU_PASS_A;
                        ctrl_d.pc_src   = PC_BEQ;
                        ctrl_d.pc_write = 1'b1;
                    end
                    CL_J: begin
                        ctrl_d.pc_write = 1'b1;
                        ctrl_d.pc_src   = PC_ZEXT;
                    end
                    CL_JAL: begin
                        ctrl_d.pc_write = 1'b1;
                        ctrl_d.pc_src   = PC_ZEXT;
                        ctrl_d.ra_write = 1'b1;
                        ctrl_d.ra_src   = RA_PC;
                    end
                    CL_JR: begin
                        ctrl_d.pc_write = 1'b1;
                        ctrl_d.pc_src   = PC_RA;
                    end
                    CL_IN: begin
                        ctrl_d.mary_src   = MSRC_IO;
                        ctrl_d.mary_write = 1'b1;
                    end
                    CL_OUT: begin
                        ctrl_d.mem_dst   = MD_IO;
                        ctrl_d.mem_write = 1'b1;
                    end
                    default: ctrl_d = '0;
                endcase
            end
            S_MEM: begin
                ctrl_d.mem_src   = MS_COMP;
                ctrl_d.mem_write = (iclass == CL_SW);
            end
            S_WB: begin
                if (instruction[0]) begin
                    ctrl_d.shelley_write = 1'b1;
                    ctrl_d.shelley_src   = (iclass == CL_LW) ? MSRC_MEM : MSRC_ALU;
                end else begin
                    ctrl_d.mary_write = 1'b1;
                    ctrl_d.mary_src   = (iclass == CL_LW) ? MSRC_MEM : MSRC_ALU;
                end
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_RESET;
            ctrl_q    <= '0;
            rst_cnt_q <= '0;
            illegal_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            if (state_q == S_RESET) rst_cnt_q <= rst_cnt_q + 2'd1;
            if (state_q == S_DECODE && iclass == CL_ILLEGAL) illegal_q <= 1'b1;
            if (state_q == S_EXEC && alu_class && overflow) ovf_q <= 1'b1;
        end
    end

    assign MemWrite        = ctrl_q.mem_write;
    assign PCWrite         = ctrl_q.pc_write;
    assign SPWrite         = ctrl_q.sp_write;
    assign InstWrite       = ctrl_q.inst_write;
    assign mary_write      = ctrl_q.mary_write;
    assign shelley_write   = ctrl_q.shelley_write;
    assign comp_write      = ctrl_q.comp_write;
    assign ra_write        = ctrl_q.ra_write;
    assign MemSrc          = ctrl_q.mem_src;
    assign MemDst          = ctrl_q.mem_dst;
    assign PCSrc           = ctrl_q.pc_src;
    assign SPSrc           = ctrl_q.sp_src;
    assign mary_src        = ctrl_q.mary_src;
    assign shelley_src     = ctrl_q.shelley_src;
    assign ra_src          = ctrl_q.ra_src;
    assign SrcA            = ctrl_q.src_a;
    assign SrcB            = ctrl_q.src_b;
    assign AluOp           = ctrl_q.alu_op;
    assign halted          = (state_q == S_HALT);
    assign illegal         = illegal_q;
    assign overflow_sticky = ovf_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: stimulus queues a hand-computed output vector per cycle;
// a negedge monitor pops and compares it against the DUT outputs.
module tb_multicycle_control_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] instruction;
    logic        overflow;
    logic        MemWrite, PCWrite, SPWrite, InstWrite;
    logic        mary_write, shelley_write, comp_write, ra_write;
    logic [1:0]  MemSrc;
    logic [2:0]  MemDst, PCSrc;
    logic [1:0]  SPSrc, mary_src, shelley_src;
    logic        ra_src, SrcA;
    logic [1:0]  SrcB;
    logic [3:0]  AluOp;
    logic        halted, illegal, overflow_sticky;
    logic [2:0]  state_dbg;

    multicycle_control_unit #(.RESET_PC_CYCLES(1), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clock(clock), .reset(reset), .instruction(instruction), .overflow(overflow),
        .MemWrite(MemWrite), .PCWrite(PCWrite), .SPWrite(SPWrite), .InstWrite(InstWrite),
        .mary_write(mary_write), .shelley_write(shelley_write), .comp_write(comp_write),
        .ra_write(ra_write), .MemSrc(MemSrc), .MemDst(MemDst), .PCSrc(PCSrc), .SPSrc(SPSrc),
        .mary_src(mary_src), .shelley_src(shelley_src), .ra_src(ra_src), .SrcA(SrcA),
        .SrcB(SrcB), .AluOp(AluOp), .halted(halted), .illegal(illegal),
        .overflow_sticky(overflow_sticky), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        logic [35:0] v;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [2:0]  fl;

    always @(posedge clock) cyc <= cyc + 1;

    // {state, halted, illegal, ovf, strobes, MemSrc, MemDst, PCSrc, SPSrc=0,
    //  mary_src, shelley_src, ra_src, SrcA, SrcB, AluOp}
    // strobe order: MemWrite PCWrite SPWrite InstWrite mary shelley comp ra
    function automatic logic [35:0] mk(input logic [2:0] st, input logic [2:0] f,
                                       input logic [7:0] stb, input logic [1:0] ms,
                                       input logic [2:0] md, input logic [2:0] pcs,
                                       input logic [1:0] msrc, input logic [1:0] ssrc,
                                       input logic ras, input logic sa,
                                       input logic [1:0] sbs, input logic [3:0] aop);
        return {st, f, stb, ms, md, pcs, 2'b00, msrc, ssrc, ras, sa, sbs, aop};
    endfunction

    wire [35:0] obs = {state_dbg, halted, illegal, overflow_sticky,
                       MemWrite, PCWrite, SPWrite, InstWrite,
                       mary_write, shelley_write, comp_write, ra_write,
                       MemSrc, MemDst, PCSrc, SPSrc, mary_src, shelley_src,
                       ra_src, SrcA, SrcB, AluOp};

    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                failures++;
                $display("FAIL %s stale entry for cycle %0d at cycle %0d", e.name, e.cyc, cyc);
            end else if (obs !== e.v) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%h exp=%h diff=%h", e.name, cyc, obs, e.v, obs ^ e.v);
            end
        end
    end

    // Queue this cycle's expected outputs, then advance one clock.
    task automatic chk(input logic [35:0] v, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.v    = v;
        e.name = name;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [15:0] instr, input string name);
        instruction = instr;
        chk(mk(3'd1, fl, 8'b0101_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0), {name, "_fetch"});
        chk(mk(3'd2, fl, 8'b0000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0), {name, "_decode"});
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        instruction = 16'h0000;
        overflow = 1'b0;
        fl = 3'b000;
        @(posedge clock);
        #1;
        chk(mk(0, fl, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "reset1");
        chk(mk(0, fl, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "reset2");
        reset = 1'b0;
        chk(mk(0, fl, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "reset_hold");

        fetch(16'h0000, "add");
        chk(mk(3, fl, 8'b0000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0), "add_exec");
        chk(mk(5, fl, 8'b0000_1000, 0, 0, 0, 0, 0, 0, 0, 0, 0), "add_wb");

        fetch(16'h1401, "lw");
        chk(mk(3, fl, 8'b0000_0010, 0, 0, 0, 0, 0, 0, 0, 2, 0), "lw_exec");
        chk(mk(4, fl, 8'b0000_0000, 2, 0, 0, 0, 0, 0, 0, 0, 0), "lw_mem");
        chk(mk(5, fl, 8'b0000_0100, 0, 0, 0, 0, 1, 0, 0, 0, 0), "lw_wb");

        fetch(16'h2400, "jal");
        chk(mk(3, fl, 8'b0100_0001, 0, 0, 1, 0, 0, 1, 0, 0, 0), "jal_exec");

        fetch(16'h0401, "sub");
        chk(mk(3, fl, 8'b0000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 1), "sub_exec");
        chk(mk(5, fl, 8'b0000_0100, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sub_wb");

        fetch(16'h1C00, "beq");
        chk(mk(3, fl, 8'b0100_0000, 0, 0, 3, 0, 0, 0, 0, 0, 4), "beq_exec");

        fetch(16'h1800, "sw");
        chk(mk(3, fl, 8'b0000_0010, 0, 0, 0, 0, 0, 0, 0, 2, 0), "sw_exec");
        chk(mk(4, fl, 8'b1000_0000, 2, 0, 0, 0, 0, 0, 0, 0, 0), "sw_mem");

        fetch(16'h2C00, "in");
        chk(mk(3, fl, 8'b0000_1000, 0, 0, 0, 2, 0, 0, 0, 0, 0), "in_exec");

        fetch(16'h3000, "out");
        chk(mk(3, fl, 8'b1000_0000, 0, 1, 0, 0, 0, 0, 0, 0, 0), "out_exec");

        fetch(16'h1002, "addi");
        chk(mk(3, fl, 8'b0000_0000, 0, 0, 0, 0, 0, 0, 0, 1, 0), "addi_exec");
        chk(mk(5, fl, 8'b0000_1000, 0, 0, 0, 0, 0, 0, 0, 0, 0), "addi_wb");

        fetch(16'h2000, "j");
        chk(mk(3, fl, 8'b0100_0000, 0, 0, 1, 0, 0, 0, 0, 0, 0), "j_exec");

        fetch(16'h2800, "jr");
        chk(mk(3, fl, 8'b0100_0000, 0, 0, 2, 0, 0, 0, 0, 0, 0), "jr_exec");

        fetch(16'h0801, "and");
        chk(mk(3, fl, 8'b0000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 2), "and_exec");
        chk(mk(5, fl, 8'b0000_0100, 0, 0, 0, 0, 0, 0, 0, 0, 0), "and_wb");

        fetch(16'h0C00, "or");
        chk(mk(3, fl, 8'b0000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 3), "or_exec");
        chk(mk(5, fl, 8'b0000_1000, 0, 0, 0, 0, 0, 0, 0, 0, 0), "or_wb");

        // Overflow during EXEC of an ADD sets the sticky flag from WB onward.
        fetch(16'h0000, "addovf");
        overflow = 1'b1;
        chk(mk(3, fl, 8'b0000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0), "addovf_exec");
        overflow = 1'b0;
        fl = 3'b001;
        chk(mk(5, fl, 8'b0000_1000, 0, 0, 0, 0, 0, 0, 0, 0, 0), "addovf_wb");

        // Illegal opcode 15 halts with both flags; strobes stay low.
        fetch(16'h3C00, "illegal");
        fl = 3'b111;
        for (int i = 0; i < 10; i++)
            chk(mk(7, fl, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "illegal_halt");
        reset = 1'b1;
        chk(mk(7, fl, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "illegal_halt_rst");
        reset = 1'b0;
        fl = 3'b000;
        chk(mk(0, fl, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "illegal_cleared");

        // HALT opcode halts without flagging illegal.
        fetch(16'hFC00, "halt");
        fl = 3'b100;
        for (int i = 0; i < 3; i++)
            chk(mk(7, fl, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "halt_state");
        reset = 1'b1;
        chk(mk(7, fl, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "halt_rst");
        reset = 1'b0;
        fl = 3'b000;
        chk(mk(0, fl, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "halt_cleared");

        // Reset sampled on the edge that would enter SW's memory cycle.
        fetch(16'h1800, "swabort");
        reset = 1'b1;
        chk(mk(3, fl, 8'b0000_0010, 0, 0, 0, 0, 0, 0, 0, 2, 0), "swabort_exec");
        reset = 1'b0;
        instruction = 16'h0000;
        chk(mk(0, fl, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "swabort_reset");

        fetch(16'h0001, "recover");
        chk(mk(3, fl, 8'b0000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0), "recover_exec");
        chk(mk(5, fl, 8'b0000_0100, 0, 0, 0, 0, 0, 0, 0, 0, 0), "recover_wb");
        chk(mk(1, fl, 8'b0101_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0), "recover_fetch");

        @(negedge clock);
        @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
